// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: samples scanned anode/cathode lines, accepts stable patterns, decodes glyphs into digits[15:0]/digit_valid and flags frame_done, changed, anode_err, scan_timeout
module seg7_scan_decoder #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  anode,
  input  logic [6:0]  cathode,
  output logic [15:0] digits,
  output logic [3:0]  digit_valid,
  output logic        frame_done,
  output logic        changed,
  output logic        anode_err,
  output logic        scan_timeout
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CACC = CW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);
  logic [10:0]   in_q;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tcnt, tcnt_nxt;
  logic [3:0]    seen, seen_nxt, sel, valid_nxt;
  logic [19:0]   snap;
  logic [15:0]   digits_nxt;
  logic [4:0]    dec;
  logic          same, accept, single, multi;
  function automatic logic [4:0] decode(input logic [6:0] c);
    case (c)
      7'h40: decode = 5'h10;
      7'h79: decode = 5'h11;
      7'h24: decode = 5'h12;
      7'h30: decode = 5'h13;
      7'h19: decode = 5'h14;
      7'h12: decode = 5'h15;
      7'h02: decode = 5'h16;
      7'h78: decode = 5'h17;
      7'h00: decode = 5'h18;
      7'h10: decode = 5'h19;
      7'h08: decode = 5'h1A;
      7'h03: decode = 5'h1B;
      7'h46: decode = 5'h1C;
      7'h21: decode = 5'h1D;
      7'h06: decode = 5'h1E;
      7'h0E: decode = 5'h1F;
      default: decode = 5'h00;
    endcase
  endfunction
  assign same     = {anode, cathode} == in_q;
  assign accept   = same && cnt == CACC;
  assign sel      = ~in_q[10:7];
  assign single   = sel != 4'd0 && (sel & (sel - 4'd1)) == 4'd0;
  assign multi    = sel != 4'd0 && !single;
  assign dec      = decode(in_q[6:0]);
  assign tcnt_nxt = accept ? '0 : (tcnt == TMAX ? TMAX : tcnt + 1'b1);
  always_comb begin
    digits_nxt = digits;
    valid_nxt  = digit_valid;
    seen_nxt   = seen;
    for (int i = 0; i < 4; i++)
      if (accept && single && sel[i]) begin
        digits_nxt[4*i +: 4] = dec[3:0];
        valid_nxt[i]         = dec[4];
        seen_nxt[i]          = 1'b1;
      end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      in_q         <= 11'h7FF;
      cnt          <= '0;
      tcnt         <= '0;
      seen         <= '0;
      snap         <= '0;
      digits       <= '0;
      digit_valid  <= '0;
      frame_done   <= 1'b0;
      changed      <= 1'b0;
      anode_err    <= 1'b0;
      scan_timeout <= 1'b0;
    end else begin
      in_q         <= {anode, cathode};
      cnt          <= !same ? '0 : (cnt == CMAX ? CMAX : cnt + 1'b1);
      tcnt         <= tcnt_nxt;
      scan_timeout <= tcnt_nxt == TMAX;
      digits       <= digits_nxt;
      digit_valid  <= valid_nxt;
      anode_err    <= anode_err | (accept & multi);
      frame_done   <= &seen_nxt;
      changed      <= &seen_nxt && {digits_nxt, valid_nxt} != snap;
      seen         <= &seen_nxt ? '0 : seen_nxt;
      if (&seen_nxt) snap <= {digits_nxt, valid_nxt};
    end
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: directed and random scans checked against a window-based reference model
module tb_seg7_scan_decoder;
  localparam int S = 4;
  localparam int T = 50;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  anode = 4'hF;
  logic [6:0]  cathode = 7'h7F;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic        frame_done, changed, anode_err, scan_timeout;
  int checks = 0, errors = 0, fd_cnt = 0, ch_cnt = 0;
  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [11:0] hist[$];
  logic [15:0] md;
  logic [3:0]  mv, mseen;
  logic [19:0] msnap;
  logic        merr, mfd, mch;
  int          idle;
  seg7_scan_decoder #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .anode(anode), .cathode(cathode),
    .digits(digits), .digit_valid(digit_valid), .frame_done(frame_done),
    .changed(changed), .anode_err(anode_err), .scan_timeout(scan_timeout)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    hist = {12'hFFF, 12'h7FF};
    md = '0; mv = '0; mseen = '0; msnap = '0;
    merr = 0; mfd = 0; mch = 0; idle = 0;
  endtask
  // accept when the last S+1 samples match and the one before them did not
  task automatic model_edge(input logic [10:0] x);
    logic acc, ok;
    int z, i;
    logic [3:0] nib;
    hist.push_back({1'b0, x});
    if (hist.size() > S + 2) void'(hist.pop_front());
    acc = hist.size() == S + 2 && hist[0] != {1'b0, x};
    for (int j = 1; j <= S + 1; j++) if (hist.size() > j && hist[j] != {1'b0, x}) acc = 0;
    mfd = 0; mch = 0;
    if (acc) idle = 0; else idle++;
    if (acc) begin
      z = 4 - $countones(x[10:7]);
      if (z >= 2) merr = 1;
      if (z == 1) begin
        i = 0;
        for (int j = 0; j < 4; j++) if (!x[7+j]) i = j;
        nib = 0; ok = 0;
        for (int j = 0; j < 16; j++) if (glyph[j] == x[6:0]) begin nib = 4'(j); ok = 1; end
        md[4*i +: 4] = nib;
        mv[i] = ok;
        mseen[i] = 1;
        if (mseen == 4'hF) begin
          mfd = 1;
          mch = {md, mv} != msnap;
          msnap = {md, mv};
          mseen = 0;
        end
      end
    end
  endtask
  task automatic check_all();
    chk("digits", 32'(digits), 32'(md));
    chk("digit_valid", 32'(digit_valid), 32'(mv));
    chk("frame_done", 32'(frame_done), 32'(mfd));
    chk("changed", 32'(changed), 32'(mch));
    chk("anode_err", 32'(anode_err), 32'(merr));
    chk("scan_timeout", 32'(scan_timeout), 32'(idle >= T));
  endtask
  task automatic step(input logic [3:0] a, input logic [6:0] c);
    anode = a;
    cathode = c;
    @(posedge clk);
    model_edge({a, c});
    #1;
    check_all();
    fd_cnt += int'(frame_done);
    ch_cnt += int'(changed);
  endtask
  task automatic scan(input int i, input logic [6:0] c, input int hold);
    repeat (hold) step(4'(~(4'b1 << i)), c);
    repeat (2) step(4'hF, 7'h7F);
  endtask
  task automatic frame(input logic [6:0] c0, c1, c2, c3);
    scan(0, c0, 8); scan(1, c1, 8); scan(2, c2, 8); scan(3, c3, 8);
  endtask
  task automatic do_reset();
    anode = 4'hF;
    cathode = 7'h7F;
    reset = 1'b0;
    #1;
    chk("rst_digits", 32'(digits), 0);
    chk("rst_valid", 32'(digit_valid), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_changed", 32'(changed), 0);
    chk("rst_anode_err", 32'(anode_err), 0);
    chk("rst_timeout", 32'(scan_timeout), 0);
    model_reset();
    @(posedge clk);
    #2 reset = 1'b1;
  endtask
  initial begin
    logic [3:0] a;
    logic [6:0] c;
    #2 do_reset();
    fd_cnt = 0; ch_cnt = 0;
    frame(7'h79, 7'h24, 7'h30, 7'h19);
    chk("f1_digits", 32'(digits), 32'h4321);
    chk("f1_valid", 32'(digit_valid), 32'hF);
    chk("f1_frames", fd_cnt, 1);
    chk("f1_changed", ch_cnt, 1);
    fd_cnt = 0; ch_cnt = 0;
    frame(7'h79, 7'h24, 7'h30, 7'h19);
    chk("f2_frames", fd_cnt, 1);
    chk("f2_changed", ch_cnt, 0);
    fd_cnt = 0; ch_cnt = 0;
    frame(7'h79, 7'h24, 7'h0E, 7'h19);
    chk("f3_digits", 32'(digits), 32'h4F21);
    chk("f3_changed", ch_cnt, 1);
    repeat (3) step(4'b1101, 7'h02);
    repeat (2) step(4'hF, 7'h7F);
    chk("glitch_digits", 32'(digits), 32'h4F21);
    repeat (4) step(4'b1101, 7'h02);
    chk("hold4_digits", 32'(digits), 32'h4F21);
    step(4'b1101, 7'h02);
    chk("hold5_digits", 32'(digits), 32'h4F61);
    repeat (2) step(4'hF, 7'h7F);
    repeat (6) step(4'b0011, 7'h40);
    chk("multi_err", 32'(anode_err), 1);
    chk("multi_digits", 32'(digits), 32'h4F61);
    repeat (2) step(4'hF, 7'h7F);
    scan(3, 7'h7F, 8);
    chk("blank_digits", 32'(digits), 32'h0F61);
    chk("blank_valid", 32'(digit_valid), 32'h7);
    chk("err_sticky", 32'(anode_err), 1);
    repeat (30) begin
      step(4'b1110, 7'h40);
      step(4'b1110, 7'h79);
    end
    chk("timeout_set", 32'(scan_timeout), 1);
    repeat (5) step(4'b1110, 7'h40);
    chk("timeout_clr", 32'(scan_timeout), 0);
    repeat (2) step(4'hF, 7'h7F);
    scan(0, 7'h40, 8);
    scan(1, 7'h79, 8);
    do_reset();
    fd_cnt = 0;
    scan(0, 7'h40, 8); scan(1, 7'h79, 8); scan(2, 7'h24, 8);
    chk("partial_frames", fd_cnt, 0);
    scan(3, 7'h30, 8);
    chk("post_rst_frames", fd_cnt, 1);
    chk("post_rst_digits", 32'(digits), 32'h3210);
    repeat (150) begin
      a = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'(~(4'b1 << $urandom_range(0, 3)));
      c = ($urandom_range(0, 3) == 0) ? 7'($urandom) : glyph[$urandom_range(0, 15)];
      repeat ($urandom_range(1, 8)) step(a, c);
      repeat ($urandom_range(0, 3)) step(4'hF, 7'h7F);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

Receiving end of the multiplexed four-digit seven-segment interface driven by the `RISCV` top (`anode`/`cathode`). Watches the scanned anode/cathode lines, qualifies each stable digit pattern, decodes active-low segment codes back into hex nibbles and reassembles the full 16-bit displayed value. Used in self-checking benches and on-chip loopback, where register contents selected by `sel`/`wr` are verified without inspecting internal nets.

## Interface
- `STABLE_CYCLES`, 4: consecutive equal samples required before a pattern is accepted (≥2)
- `TIMEOUT_CYCLES`, 1000000: cycles without an accepted digit before `scan_timeout` asserts

- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `anode`  in  4  digit enables, active-low, bit i = digit i
- `cathode`  in  7  segments {g,f,e,d,c,b,a}, active-low
- `digits`  out  16  decoded value, digit i at [4i+3:4i]
- `digit_valid`  out  4  bit i set when digit i last decoded to a legal hex glyph
- `frame_done`  out  1  one-cycle pulse when all four digits refreshed since last pulse
- `changed`  out  1  one-cycle pulse, coincident with `frame_done`, if frame differs from previous frame
- `anode_err`  out  1  sticky: an accepted pattern had more than one anode low
- `scan_timeout`  out  1  no digit accepted for `TIMEOUT_CYCLES` cycles

## Operation
- Input register `in_q` = {anode, cathode} every edge; stability counter `cnt` (saturates at `STABLE_CYCLES`) clears when new input ≠ `in_q`, else increments.
- Accept event: edge at which `cnt` goes `STABLE_CYCLES-1` → `STABLE_CYCLES`; exactly one accept per stable window.
- On accept, by anode class:
  - all ones (blanking): ignored, no state change except timeout counter clear.
  - exactly one zero at index i: decode cathode, write nibble to digit i, set/clear `digit_valid[i]`, set `seen[i]`.
  - two or more zeros: set `anode_err`, no digit written.
- Decode table (cathode hex → nibble): 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9, 08→A, 03→b, 46→C, 21→d, 06→E, 0E→F. Any other code (incl. 7F blank): nibble 0, `digit_valid[i]`=0.
- Same digit accepted twice in one frame: overwrite value, `seen` unchanged.
- When `seen` becomes 1111: `frame_done` pulse, `seen` cleared; compare {digits, digit_valid} against stored previous-frame snapshot → `changed`; snapshot updated.
- Timeout counter: cleared on every accept (any class), else increments, saturating; `scan_timeout` = counter ≥ `TIMEOUT_CYCLES`; clears on next accept.

## Timing
- Reset (async, `reset`=0): `digits`=0, `digit_valid`=0, `frame_done`=0, `changed`=0, `anode_err`=0, `scan_timeout`=0; internal `in_q`=all ones, `cnt`=0, `seen`=0, snapshot=0, timeout counter=0. Partial frame in progress is discarded.
- Pattern first captured into `in_q` at edge e0 and held: `digits`/`digit_valid` update at edge e0+`STABLE_CYCLES`; glitches lasting fewer than `STABLE_CYCLES`+1 edges are never accepted.
- `frame_done`/`changed` registered: high for the one cycle following the accept edge that completes `seen`.
- `anode_err` sets at the accept edge; cleared only by reset.
- All outputs registered; no combinational input→output path.

## Test plan
- Reset, then scan digits 0..3 with cathode 79,24,30,19 (held 8 cycles each, 2-cycle blank between) → `digits`=16'h4321, `digit_valid`=1111, one `frame_done` with `changed`=1.
- Repeat identical scan → second `frame_done` with `changed`=0; change digit 2 to 0E → next frame `digits`=16'h4F21, `changed`=1.
- Apply digit 1 pattern for 3 edges only (`STABLE_CYCLES`=4) → no update to `digits`, `seen` not advanced; holding 5 edges → update exactly at e0+4.
- Drive anode=0011 stable → `anode_err`=1 and stays; `digits` unchanged; cathode 7F on digit 3 → nibble 0, `digit_valid[3]`=0.
- `TIMEOUT_CYCLES`=50, hold blank-free glitching inputs → `scan_timeout`=1 after 50 cycles, clears on next accepted pattern.
- Assert `reset` mid-frame after two digits → all outputs zero immediately; next full scan produces `frame_done` only after all four digits.
